// File: rtl/line_crossbar_pkg.sv
// Shared types and constants for the line_crossbar slice.
package line_crossbar_pkg;

  typedef enum logic [1:0] {
    IDLE,
    COMMIT,
    HOLD
  } state_e;

  localparam int unsigned HOLD_CNT_W = 4;

  // Select codes just past the last input line: +0 is constant 0, +1 is constant 1.
  function automatic int unsigned const_sel(input int unsigned num_inputs, input logic one);
    return num_inputs + (one ? 32'd1 : 32'd0);
  endfunction

endpackage

// File: rtl/line_crossbar_lane.sv
// One crossbar output: source mux, constant sources, invert and freezable output flop.
module line_crossbar_lane
  import line_crossbar_pkg::*;
#(
  parameter int unsigned NUM_INPUTS = 10,
  parameter int unsigned ISEL_W     = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_INPUTS-1:0] lines_i,
  input  logic [ISEL_W-1:0]     sel_i,
  input  logic                  inv_i,
  input  logic                  freeze_i,
  output logic                  line_o
);

  logic routed;
  logic line_d, line_q;

  always_comb begin
    routed = 1'b0;
    for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
      if (sel_i == ISEL_W'(i)) routed = lines_i[i];
    end
    if (sel_i == ISEL_W'(const_sel(NUM_INPUTS, 1'b1))) routed = 1'b1;
    line_d = freeze_i ? line_q : (routed ^ inv_i);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) line_q <= 1'b0;
    else     line_q <= line_d;
  end

  assign line_o = line_q;

endmodule

// File: rtl/line_crossbar.sv
// Reconfigurable N x M line crossbar with shadow/active route tables and post-commit hold.
// Optional input synchronizers: define LINE_CROSSBAR_SYNC_EN.
module line_crossbar
  import line_crossbar_pkg::*;
#(
  parameter  int unsigned NUM_INPUTS  = 10,
  parameter  int unsigned NUM_OUTPUTS = 10,
  parameter  int unsigned HOLD_CYCLES = 2,
  parameter  int unsigned SYNC_STAGES = 2,
  localparam int unsigned ISEL_W      = $clog2(NUM_INPUTS + 2),
  localparam int unsigned OSEL_W      = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_INPUTS-1:0]  input_lines,
  output logic [NUM_OUTPUTS-1:0] output_lines,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic [OSEL_W-1:0]      cfg_output_select,
  input  logic [ISEL_W-1:0]      cfg_input_select,
  input  logic                   cfg_invert,
  input  logic                   commit,
  output logic                   busy,
  output logic                   cfg_error
);

  localparam logic [ISEL_W-1:0] SEL_RST = ISEL_W'(const_sel(NUM_INPUTS, 1'b0));

  if (NUM_INPUTS < 1 || NUM_INPUTS > 64 || NUM_OUTPUTS < 1 || NUM_OUTPUTS > 64 ||
      HOLD_CYCLES > 15 || SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_param_check
    $error("line_crossbar: parameter out of range");
  end

  logic [NUM_INPUTS-1:0] lines_s;

`ifdef LINE_CROSSBAR_SYNC_EN
  logic [NUM_INPUTS-1:0] sync_q [SYNC_STAGES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= input_lines;
      for (int unsigned s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  assign lines_s = sync_q[SYNC_STAGES-1];
`else
  assign lines_s = input_lines;
`endif

  logic [ISEL_W-1:0]     act_sel_q [NUM_OUTPUTS];
  logic [ISEL_W-1:0]     shd_sel_q [NUM_OUTPUTS];
  logic [NUM_OUTPUTS-1:0] act_inv_q, shd_inv_q, changed_q, diff;
  logic [HOLD_CNT_W-1:0] hold_cnt_q;
  logic                  cfg_error_q, rdy_en_q;
  logic                  wr_fire, wr_bad, wr_ok;
  state_e                state_q, state_d;

  assign wr_fire = cfg_valid && cfg_ready;
  assign wr_bad  = (32'(cfg_output_select) >= NUM_OUTPUTS) ||
                   (32'(cfg_input_select) > NUM_INPUTS + 1);
  assign wr_ok   = wr_fire && !wr_bad;

  always_comb begin
    diff = '0;
    for (int unsigned o = 0; o < NUM_OUTPUTS; o++) begin
      diff[o] = (act_sel_q[o] != shd_sel_q[o]) || (act_inv_q[o] != shd_inv_q[o]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (commit) state_d = COMMIT;
      COMMIT:  state_d = (HOLD_CYCLES == 0 || diff == '0) ? IDLE : HOLD;
      HOLD:    if (hold_cnt_q == HOLD_CNT_W'(1)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cfg_ready = 1'b0;
    busy      = 1'b1;
    if (state_q == IDLE) begin
      cfg_ready = rdy_en_q;
      busy      = 1'b0;
    end
  end

  // Shadow write precedes the COMMIT copy by one edge, so a same-cycle write is included.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned o = 0; o < NUM_OUTPUTS; o++) begin
        act_sel_q[o] <= SEL_RST;
        shd_sel_q[o] <= SEL_RST;
      end
      act_inv_q   <= '0;
      shd_inv_q   <= '0;
      changed_q   <= '0;
      hold_cnt_q  <= '0;
      cfg_error_q <= 1'b0;
      rdy_en_q    <= 1'b0;
    end else begin
      rdy_en_q    <= 1'b1;
      cfg_error_q <= wr_fire && wr_bad;
      for (int unsigned o = 0; o < NUM_OUTPUTS; o++) begin
        if (wr_ok && cfg_output_select == OSEL_W'(o)) begin
          shd_sel_q[o] <= cfg_input_select;
          shd_inv_q[o] <= cfg_invert;
        end
      end
      if (state_q == COMMIT) begin
        for (int unsigned o = 0; o < NUM_OUTPUTS; o++) act_sel_q[o] <= shd_sel_q[o];
        act_inv_q  <= shd_inv_q;
        changed_q  <= (state_d == HOLD) ? diff : '0;
        hold_cnt_q <= HOLD_CNT_W'(HOLD_CYCLES);
      end else if (state_q == HOLD) begin
        hold_cnt_q <= hold_cnt_q - HOLD_CNT_W'(1);
        if (hold_cnt_q == HOLD_CNT_W'(1)) changed_q <= '0;
      end
    end
  end

  assign cfg_error = cfg_error_q;

  for (genvar o = 0; o < NUM_OUTPUTS; o++) begin : g_lane
    line_crossbar_lane #(
      .NUM_INPUTS(NUM_INPUTS),
      .ISEL_W    (ISEL_W)
    ) u_lane (
      .clk     (clk),
      .rst     (rst),
      .lines_i (lines_s),
      .sel_i   (act_sel_q[o]),
      .inv_i   (act_inv_q[o]),
      .freeze_i(changed_q[o]),
      .line_o  (output_lines[o])
    );
  end

endmodule

// File: tb/tb_line_crossbar.sv
// Scoreboard bench for line_crossbar: stimulus queues expected values tagged by cycle, a monitor checks them.
module tb_line_crossbar;

  localparam int unsigned NI = 10;
  localparam int unsigned NO = 10;
  localparam int unsigned SIG_OUT = 0, SIG_BUSY = 1, SIG_RDY = 2, SIG_ERR = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [NI-1:0] input_lines;
  logic [NO-1:0] output_lines;
  logic          cfg_valid, cfg_ready, cfg_invert, commit, busy, cfg_error;
  logic [3:0]    cfg_output_select;
  logic [3:0]    cfg_input_select;

  line_crossbar #(
    .NUM_INPUTS (NI),
    .NUM_OUTPUTS(NO),
    .HOLD_CYCLES(2),
    .SYNC_STAGES(2)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .input_lines      (input_lines),
    .output_lines     (output_lines),
    .cfg_valid        (cfg_valid),
    .cfg_ready        (cfg_ready),
    .cfg_output_select(cfg_output_select),
    .cfg_input_select (cfg_input_select),
    .cfg_invert       (cfg_invert),
    .commit           (commit),
    .busy             (busy),
    .cfg_error        (cfg_error)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned at;
    int unsigned sig;
    logic [63:0] val;
    string       name;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic push(input int unsigned off, input int unsigned sig, input logic [63:0] val,
                      input string name);
    exp_t e;
    e.at = cyc + off; e.sig = sig; e.val = val; e.name = name;
    q.push_back(e);
  endtask

  function automatic logic [63:0] actual(input int unsigned sig);
    case (sig)
      SIG_OUT:  return 64'(output_lines);
      SIG_BUSY: return 64'(busy);
      SIG_RDY:  return 64'(cfg_ready);
      default:  return 64'(cfg_error);
    endcase
  endfunction

  always @(negedge clk) begin
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].at == cyc) begin
        checks++;
        if (actual(q[i].sig) !== q[i].val) begin
          failures++;
          $display("FAIL %s cyc=%0d got=%0h expected=%0h", q[i].name, cyc, actual(q[i].sig), q[i].val);
        end
        q.delete(i);
      end else if (q[i].at < cyc) begin
        checks++;
        failures++;
        $display("FAIL %s cyc=%0d got=unsampled expected=%0h", q[i].name, q[i].at, q[i].val);
        q.delete(i);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int unsigned k);
    repeat (k) step();
  endtask

  task automatic write(input logic [3:0] osel, input logic [3:0] isel, input logic inv,
                       input logic err);
    push(1, SIG_ERR, 64'(err), "cfg_error pulse");
    push(2, SIG_ERR, 64'd0, "cfg_error clear");
    cfg_valid = 1'b1; cfg_output_select = osel; cfg_input_select = isel; cfg_invert = inv;
    step();
    cfg_valid = 1'b0;
  endtask

  task automatic do_commit();
    commit = 1'b1;
    step();
    commit = 1'b0;
  endtask

  // Called right after the commit edge n (cyc == n).
  task automatic expect_commit(input logic changed);
    push(0, SIG_BUSY, 64'd1, "busy commit");
    if (changed) begin
      push(1, SIG_BUSY, 64'd1, "busy hold1");
      push(2, SIG_BUSY, 64'd1, "busy hold2");
      push(3, SIG_BUSY, 64'd0, "busy end");
      push(3, SIG_RDY,  64'd1, "ready back");
    end else begin
      push(1, SIG_BUSY, 64'd0, "busy end nochange");
      push(1, SIG_RDY,  64'd1, "ready back nochange");
    end
  endtask

  initial begin
    rst = 1'b1; input_lines = '1; cfg_valid = 1'b0; commit = 1'b0;
    cfg_output_select = '0; cfg_input_select = '0; cfg_invert = 1'b0;

    // Reset behaviour and cfg_ready release
    push(1, SIG_OUT,  64'd0, "reset out");
    push(1, SIG_BUSY, 64'd0, "reset busy");
    push(1, SIG_RDY,  64'd0, "reset ready");
    push(3, SIG_RDY,  64'd0, "ready at release");
    push(3, SIG_ERR,  64'd0, "reset error");
    push(4, SIG_RDY,  64'd1, "ready rises");
    push(4, SIG_OUT,  64'd0, "out after reset");
    push(4, SIG_BUSY, 64'd0, "busy after reset");
    idle(3);
    rst = 1'b0;
    idle(1);

    // out3 <- in5, held 2 cycles then tracking
    write(4'd3, 4'd5, 1'b0, 1'b0);
    do_commit();
    expect_commit(1'b1);
    push(0, SIG_OUT, 64'h000, "out3 old route");
    push(1, SIG_OUT, 64'h000, "out3 old route2");
    push(2, SIG_OUT, 64'h000, "out3 frozen1");
    push(3, SIG_OUT, 64'h000, "out3 frozen2");
    push(4, SIG_OUT, 64'h008, "out3 released");
    idle(4);
    input_lines[5] = 1'b0;
    push(1, SIG_OUT, 64'h000, "out3 follows low");
    step();
    input_lines[5] = 1'b1;
    push(1, SIG_OUT, 64'h008, "out3 follows high");
    step();

    // out0 <- constant 1, inverted then plain
    write(4'd0, 4'd11, 1'b1, 1'b0);
    do_commit();
    expect_commit(1'b1);
    push(4, SIG_OUT, 64'h008, "const1 inverted");
    idle(4);
    write(4'd0, 4'd11, 1'b0, 1'b0);
    do_commit();
    expect_commit(1'b1);
    push(3, SIG_OUT, 64'h008, "out0 frozen");
    push(4, SIG_OUT, 64'h009, "const1 plain");
    idle(4);

    // Rejected writes leave shadow unchanged
    write(4'd10, 4'd0, 1'b0, 1'b1);
    idle(1);
    write(4'd2, 4'd12, 1'b0, 1'b1);
    idle(1);
    do_commit();
    expect_commit(1'b0);
    push(1, SIG_OUT, 64'h009, "out after rejected");
    idle(2);

    // Same-cycle write and commit; unchanged lanes keep tracking during hold
    input_lines[2] = 1'b0;
    cfg_valid = 1'b1; cfg_output_select = 4'd7; cfg_input_select = 4'd2; cfg_invert = 1'b1;
    commit = 1'b1;
    push(1, SIG_ERR, 64'd0, "no error on combined");
    step();
    cfg_valid = 1'b0; commit = 1'b0;
    expect_commit(1'b1);
    push(0, SIG_OUT, 64'h009, "combined pre");
    input_lines[5] = 1'b0;
    push(1, SIG_OUT, 64'h001, "track during commit");
    step();
    input_lines[5] = 1'b1;
    push(1, SIG_OUT, 64'h009, "out7 frozen1 out3 tracks");
    step();
    input_lines[5] = 1'b0;
    push(1, SIG_OUT, 64'h001, "out7 frozen2");
    step();
    push(1, SIG_OUT, 64'h081, "out7 released");
    idle(2);

    // Reset during hold
    input_lines = '1;
    write(4'd1, 4'd0, 1'b0, 1'b0);
    do_commit();
    push(0, SIG_OUT,  64'h009, "pre-reset out");
    push(0, SIG_BUSY, 64'd1,   "pre-reset busy");
    step();
    rst = 1'b1;
    push(0, SIG_OUT,  64'h000, "reset mid-hold out");
    push(0, SIG_BUSY, 64'd0,   "reset mid-hold busy");
    push(0, SIG_RDY,  64'd0,   "reset mid-hold ready");
    step();
    rst = 1'b0;
    push(1, SIG_RDY,  64'd1,   "ready after reset2");
    push(1, SIG_OUT,  64'h000, "out after reset2");
    idle(1);
    do_commit();
    expect_commit(1'b0);
    push(0, SIG_OUT, 64'h000, "reset table commit");
    push(2, SIG_OUT, 64'h000, "reset table after");
    idle(4);

    if (q.size() != 0) begin
      failures += q.size();
      $display("FAIL scoreboard leftover got=%0d expected=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
